multi_operand_calc: RTL and testbench
=====================================

Name: multi_operand_calc

Overview:
- Parametrised successor to the two-operand button calculator.
- Collects NUM_OPERANDS operands from the switch bus, one per debounced button press.
- Accumulates the operands in add or subtract mode, converts the signed result to BCD with a sequential double-dabble engine, and drives DIGITS seven-segment outputs plus a sign flag.
- Sits at chip top level between the switch/button pads and the display pads.

Parameters:
WIDTH, 4, operand width in bits (2..8)
NUM_OPERANDS, 2, operands per calculation (2..8)
DIGITS, 2, number of decimal display digits (1..4)
DEBOUNCE_CYCLES, 250000, stable cycles required before a button level is accepted (>=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
button  in  1  raw push button, asynchronous, active-high
mode  in  1  0 = add all operands, 1 = first operand minus each later operand; sampled on the first operand press
x  in  WIDTH  unsigned operand switches
seg  out  7*DIGITS  segment patterns, digit 0 (ones) in bits [6:0]; bit0=a..bit6=g; active-high
neg  out  1  result is negative
ovf  out  1  |result| exceeds 10^DIGITS-1
op_idx  out  3  index of the next operand to be captured
busy  out  1  conversion in progress

Behaviour:
- Reset (async assert, sync release via 2-flop synchroniser on rst deassertion):
  - state=IDLE, accumulator=0, op_idx=0, neg=0, ovf=0, busy=0.
  - All digits show blank (7'b0000000).
- Button input path:
  - 2-flop synchroniser, then debounce counter: the filtered level changes only after DEBOUNCE_CYCLES consecutive cycles of the new raw level.
  - A press is the rising edge of the filtered level: a single-cycle internal pulse.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
- Arithmetic:
  - ACC_W = WIDTH+clog2(NUM_OPERANDS)+1, signed.
  - Operands are zero-extended to ACC_W.
  - No overflow is possible within the accumulator.
- FSM states:
  - IDLE: shows blanks.
    - Press -> acc=x, latch mode, op_idx=1, go to CAPTURE.
  - CAPTURE: display shows the accumulator magnitude is NOT required; display stays blank.
    - Press -> acc = acc±x, op_idx+1.
    - If op_idx reaches NUM_OPERANDS after the update, go to CONVERT next cycle.
  - CONVERT:
    - busy=1. Entry cycle loads |acc| into the shift register and sets neg = acc<0.
    - Then one shift/add-3 iteration per cycle for ACC_W cycles.
    - busy deasserts and state=SHOW exactly ACC_W+1 cycles after entry.
    - Presses during CONVERT are discarded.
  - SHOW:
    - Digits show BCD with leading zeros.
    - If ovf, all digits show dash (7'b1000000); ovf is computed from the full BCD result.
    - Press -> same as the IDLE press: starts a new calculation with x as the first operand; neg/ovf clear.
- Simultaneous events: rst dominates everything. A press coinciding with the CAPTURE->CONVERT transition cycle is discarded.
- Reset mid-operation: the state machine returns to IDLE immediately (async); the debounce counter clears, so a held button must be released and pressed again.
- Segment decode: digits 0-9 use standard patterns, e.g. 0=7'h3F, 1=7'h06, 6=7'h7D, 9=7'h6F.
- op_idx saturates; it resets to 0 on entry to SHOW.

Decomposition:
- Package calc_pkg:
  - state enum (IDLE, CAPTURE, CONVERT, SHOW)
  - SEG_BLANK, SEG_DASH
  - digit-to-segment constant function
  - ACC_W computation function
- Sub-module debounce (synchroniser, counter and rising-edge pulse), parametrised by DEBOUNCE_CYCLES.
- Double-dabble engine and FSM stay in the top block.

Test Plan:
- Defaults (DEBOUNCE_CYCLES=4 in sim), mode=0, press x=7 then x=9 -> after ACC_W+1 cycles busy=0, seg[13:7]=7'h06, seg[6:0]=7'h7D, neg=0, ovf=0.
- mode=1, x=3 then x=9 -> neg=1, digits "06" (7'h3F, 7'h7D).
- NUM_OPERANDS=3, mode=0, x=15 three times -> digits "45" (7'h66, 7'h6D); op_idx sequence 1,2,3, then 0.
- DIGITS=1, 9+9 -> ovf=1, seg=7'h40.
- Raw button pulse of 3 cycles -> no capture, op_idx unchanged.
- rst asserted mid-CONVERT -> same-cycle state IDLE, busy=0, seg all 0.
- Press during CONVERT -> ignored, result unchanged.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types, display constants and sizing helpers for the multi-operand calculator.
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        CONVERT = 2'd2,
        SHOW    = 2'd3
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;

    function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
        case (d)
            4'd0:    digit_to_seg = 7'h3F;
            4'd1:    digit_to_seg = 7'h06;
            4'd2:    digit_to_seg = 7'h5B;
            4'd3:    digit_to_seg = 7'h4F;
            4'd4:    digit_to_seg = 7'h66;
            4'd5:    digit_to_seg = 7'h6D;
            4'd6:    digit_to_seg = 7'h7D;
            4'd7:    digit_to_seg = 7'h07;
            4'd8:    digit_to_seg = 7'h7F;
            4'd9:    digit_to_seg = 7'h6F;
            default: digit_to_seg = SEG_BLANK;
        endcase
    endfunction

    function automatic int acc_width(input int width, input int num_ops);
        return width + $clog2(num_ops) + 1;
    endfunction

    // Enough BCD digits to hold any value of the given bit width.
    function automatic int bcd_digits(input int bits);
        return (bits + 2) / 3;
    endfunction

endpackage

// File: rtl/multi_operand_calc_debounce.sv
// Button conditioning: 2-flop synchroniser, down-counter debounce and rising-edge press pulse.
module debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_CYCLES - 1);

    logic meta_q, sync_q;
    logic level_q, level_d;
    logic level_prev_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Filter comes out of reset as "held", so a button held through reset never yields a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q       <= 1'b1;
            sync_q       <= 1'b1;
            level_q      <= 1'b1;
            level_prev_q <= 1'b1;
            cnt_q        <= RELOAD;
        end else begin
            meta_q       <= btn_i;
            sync_q       <= meta_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        level_d = level_q;
        cnt_d   = RELOAD;
        if (sync_q != level_q) begin
            if (cnt_q == '0) begin
                level_d = sync_q;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    assign press_o = level_q & ~level_prev_q;

endmodule

// File: rtl/multi_operand_calc.sv
// Button-driven calculator: accumulates NUM_OPERANDS switch values, converts to BCD, drives 7-seg digits.
// state   | meaning
// IDLE    | blank display, waiting for the first operand
// CAPTURE | collecting further operands into the accumulator
// CONVERT | double-dabble of |acc|, busy high
// SHOW    | result on the display, a press starts over
module multi_operand_calc
    import calc_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int NUM_OPERANDS    = 2,
    parameter int DIGITS          = 2,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  button,
    input  logic                  mode,
    input  logic [WIDTH-1:0]      x,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  neg,
    output logic                  ovf,
    output logic [2:0]            op_idx,
    output logic                  busy
);
    localparam int ACC_W = acc_width(WIDTH, NUM_OPERANDS);
    localparam int BCD_N = (bcd_digits(ACC_W) > DIGITS) ? bcd_digits(ACC_W) : DIGITS;
    localparam int SH_W  = 4 * BCD_N + ACC_W;
    localparam int CNT_W = $clog2(ACC_W + 1);
    localparam int OPC_W = $clog2(NUM_OPERANDS + 1);
    localparam logic [CNT_W-1:0] DD_LOAD = CNT_W'(ACC_W);
    localparam logic [OPC_W-1:0] OP_LAST = OPC_W'(NUM_OPERANDS);

    logic rst_meta_q, rst_int_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_meta_q <= 1'b1;
            rst_int_q  <= 1'b1;
        end else begin
            rst_meta_q <= 1'b0;
            rst_int_q  <= rst_meta_q;
        end
    end

    logic press;

    debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst_int_q),
        .btn_i  (button),
        .press_o(press)
    );

    state_e state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             mode_q, mode_d;
    logic [OPC_W-1:0] op_cnt_q, op_cnt_d;
    logic             neg_q, neg_d;
    logic [CNT_W-1:0] dd_cnt_q, dd_cnt_d;
    logic [SH_W-1:0]  shift_q, shift_d;

    logic             start, accumulate, conv_load, conv_done, all_captured;
    logic [ACC_W-1:0] x_ext, acc_mag;
    logic [SH_W-1:0]  dabble;

    assign x_ext        = {{(ACC_W-WIDTH){1'b0}}, x};
    assign all_captured = (state_q == CAPTURE) && (op_cnt_q == OP_LAST);
    assign start        = press && (state_q == IDLE || state_q == SHOW);
    assign accumulate   = press && (state_q == CAPTURE) && (op_cnt_q != OP_LAST);
    assign conv_load    = (state_q == CONVERT) && (dd_cnt_q == DD_LOAD);
    assign conv_done    = (state_q == CONVERT) && (dd_cnt_q == '0);
    assign acc_mag      = acc_q[ACC_W-1] ? -acc_q : acc_q;

    always_ff @(posedge clk or posedge rst_int_q) begin
        if (rst_int_q) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (press) state_d = CAPTURE;
            CAPTURE: if (all_captured) state_d = CONVERT;
            CONVERT: if (conv_done) state_d = SHOW;
            SHOW:    if (press) state_d = CAPTURE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q == CONVERT);
        neg    = neg_q;
        op_idx = (32'(op_cnt_q) > 7) ? 3'd7 : 3'(op_cnt_q);
        ovf    = 1'b0;
        for (int i = DIGITS; i < BCD_N; i++) begin
            if (shift_q[ACC_W + 4*i +: 4] != 4'd0) ovf = 1'b1;
        end
        if (state_q != SHOW) ovf = 1'b0;
        seg = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (state_q != SHOW)  seg[7*d +: 7] = SEG_BLANK;
            else if (ovf)         seg[7*d +: 7] = SEG_DASH;
            else                  seg[7*d +: 7] = digit_to_seg(shift_q[ACC_W + 4*d +: 4]);
        end
    end

    // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
    always_comb begin
        dabble = shift_q;
        for (int i = 0; i < BCD_N; i++) begin
            if (dabble[ACC_W + 4*i +: 4] >= 4'd5)
                dabble[ACC_W + 4*i +: 4] = dabble[ACC_W + 4*i +: 4] + 4'd3;
        end
        dabble = {dabble[SH_W-2:0], 1'b0};
    end

    always_comb begin
        acc_d    = acc_q;
        mode_d   = mode_q;
        op_cnt_d = op_cnt_q;
        neg_d    = neg_q;
        dd_cnt_d = dd_cnt_q;
        shift_d  = shift_q;
        if (start) begin
            acc_d    = x_ext;
            mode_d   = mode;
            op_cnt_d = OPC_W'(1);
            neg_d    = 1'b0;
        end else if (accumulate) begin
            acc_d    = mode_q ? (acc_q - x_ext) : (acc_q + x_ext);
            op_cnt_d = op_cnt_q + OPC_W'(1);
        end
        if (all_captured) dd_cnt_d = DD_LOAD;
        if (state_q == CONVERT) begin
            if (conv_load) begin
                shift_d = {{(4*BCD_N){1'b0}}, acc_mag};
                neg_d   = acc_q[ACC_W-1];
            end else begin
                shift_d = dabble;
            end
            if (conv_done) op_cnt_d = '0;
            else           dd_cnt_d = dd_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst_int_q) begin
        if (rst_int_q) begin
            acc_q    <= '0;
            mode_q   <= 1'b0;
            op_cnt_q <= '0;
            neg_q    <= 1'b0;
            dd_cnt_q <= '0;
            shift_q  <= '0;
        end else begin
            acc_q    <= acc_d;
            mode_q   <= mode_d;
            op_cnt_q <= op_cnt_d;
            neg_q    <= neg_d;
            dd_cnt_q <= dd_cnt_d;
            shift_q  <= shift_d;
        end
    end

endmodule

// File: tb/tb_multi_operand_calc.sv
// Bench for multi_operand_calc: four parameter sets driven with directed and random operand sequences.
module tb_multi_operand_calc;

    localparam int NI   = 4;
    localparam int HOLD = 14;
    localparam int P_W  [NI] = '{4, 4, 4, 8};
    localparam int P_N  [NI] = '{2, 3, 2, 4};
    localparam int P_D  [NI] = '{2, 2, 1, 4};
    localparam int P_DB [NI] = '{4, 4, 4, 2};

    logic clk = 1'b0;
    logic rst;
    logic [NI-1:0] btn;
    logic [NI-1:0] md;
    logic [7:0]    xv [NI];
    logic [13:0]   seg0, seg1;
    logic [6:0]    seg2;
    logic [27:0]   seg3;
    logic [NI-1:0] neg_w, ovf_w, busy_w;
    logic [3*NI-1:0] opi_w;

    int checks   = 0;
    int failures = 0;
    int busy_cnt [NI];

    always #5 clk = ~clk;

    multi_operand_calc #(.WIDTH(P_W[0]), .NUM_OPERANDS(P_N[0]), .DIGITS(P_D[0]), .DEBOUNCE_CYCLES(P_DB[0])) dut0 (
        .clk(clk), .rst(rst), .button(btn[0]), .mode(md[0]), .x(xv[0][3:0]), .seg(seg0),
        .neg(neg_w[0]), .ovf(ovf_w[0]), .op_idx(opi_w[2:0]), .busy(busy_w[0]));
    multi_operand_calc #(.WIDTH(P_W[1]), .NUM_OPERANDS(P_N[1]), .DIGITS(P_D[1]), .DEBOUNCE_CYCLES(P_DB[1])) dut1 (
        .clk(clk), .rst(rst), .button(btn[1]), .mode(md[1]), .x(xv[1][3:0]), .seg(seg1),
        .neg(neg_w[1]), .ovf(ovf_w[1]), .op_idx(opi_w[5:3]), .busy(busy_w[1]));
    multi_operand_calc #(.WIDTH(P_W[2]), .NUM_OPERANDS(P_N[2]), .DIGITS(P_D[2]), .DEBOUNCE_CYCLES(P_DB[2])) dut2 (
        .clk(clk), .rst(rst), .button(btn[2]), .mode(md[2]), .x(xv[2][3:0]), .seg(seg2),
        .neg(neg_w[2]), .ovf(ovf_w[2]), .op_idx(opi_w[8:6]), .busy(busy_w[2]));
    multi_operand_calc #(.WIDTH(P_W[3]), .NUM_OPERANDS(P_N[3]), .DIGITS(P_D[3]), .DEBOUNCE_CYCLES(P_DB[3])) dut3 (
        .clk(clk), .rst(rst), .button(btn[3]), .mode(md[3]), .x(xv[3]), .seg(seg3),
        .neg(neg_w[3]), .ovf(ovf_w[3]), .op_idx(opi_w[11:9]), .busy(busy_w[3]));

    task automatic check_val(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;  default: return 7'h00;
        endcase
    endfunction

    function automatic int get_seg(input int idx);
        case (idx)
            0:       return int'(seg0);
            1:       return int'(seg1);
            2:       return int'(seg2);
            default: return int'(seg3);
        endcase
    endfunction

    function automatic int get_opi(input int idx);
        return int'(opi_w[3*idx +: 3]);
    endfunction

    function automatic int exp_seg(input int idx, input int mag, input bit ov);
        logic [27:0] r;
        int m;
        r = '0;
        m = mag;
        for (int k = 0; k < P_D[idx]; k++) begin
            r[7*k +: 7] = ov ? 7'h40 : seg_of(m % 10);
            m = m / 10;
        end
        return int'(r);
    endfunction

    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < NI; i++) if (busy_w[i]) busy_cnt[i]++;
    endtask

    task automatic press(input int idx, input int val);
        xv[idx] = val[7:0];
        btn[idx] = 1'b1;
        repeat (HOLD) tick();
        btn[idx] = 1'b0;
        repeat (HOLD) tick();
    endtask

    task automatic glitch(input int idx);
        btn[idx] = 1'b1;
        repeat (3) tick();
        btn[idx] = 1'b0;
        repeat (HOLD) tick();
    endtask

    // Final press of a DEBOUNCE_CYCLES=2 instance followed by a second press landing mid-conversion.
    task automatic press_then_convert_press(input int idx, input int val);
        xv[idx] = val[7:0];
        btn[idx] = 1'b1;
        repeat (4) tick();
        btn[idx] = 1'b0;
        repeat (4) tick();
        xv[idx] = 8'(val + 1);
        btn[idx] = 1'b1;
        repeat (3) tick();
        btn[idx] = 1'b0;
        repeat (2*HOLD) tick();
    endtask

    task automatic run_calc(input int idx, input int mode, input int ops [8],
                            input bit flip, input bit glitch_on, input bit conv_press);
        int n, acc, mag, lim, aw;
        bit ov;
        n = P_N[idx];
        aw = P_W[idx] + $clog2(P_N[idx]) + 1;
        acc = ops[0];
        for (int k = 1; k < n; k++) acc = (mode != 0) ? acc - ops[k] : acc + ops[k];
        mag = (acc < 0) ? -acc : acc;
        lim = 1;
        for (int k = 0; k < P_D[idx]; k++) lim = lim * 10;
        ov = (mag > lim - 1);
        md[idx] = mode[0];
        busy_cnt[idx] = 0;
        for (int k = 0; k < n; k++) begin
            if (k == n-1 && conv_press) press_then_convert_press(idx, ops[k]);
            else                         press(idx, ops[k]);
            if (k == 0 && flip) md[idx] = ~md[idx];
            if (k == 0 && glitch_on) begin
                glitch(idx);
                check_val($sformatf("i%0d_glitch_op_idx", idx), get_opi(idx), 1);
            end
            if (k < n-1) check_val($sformatf("i%0d_op_idx_%0d", idx, k+1), get_opi(idx), k+1);
        end
        check_val($sformatf("i%0d_busy_cycles", idx), busy_cnt[idx], aw + 1);
        check_val($sformatf("i%0d_busy_after", idx), int'(busy_w[idx]), 0);
        check_val($sformatf("i%0d_op_idx_show", idx), get_opi(idx), 0);
        check_val($sformatf("i%0d_neg", idx), int'(neg_w[idx]), (acc < 0) ? 1 : 0);
        check_val($sformatf("i%0d_ovf", idx), int'(ovf_w[idx]), ov ? 1 : 0);
        check_val($sformatf("i%0d_seg", idx), get_seg(idx), exp_seg(idx, mag, ov));
    endtask

    initial begin
        int ops [8];
        int started;
        rst = 1'b1;
        btn = '0;
        md  = '0;
        for (int i = 0; i < NI; i++) begin
            xv[i] = 8'd0;
            busy_cnt[i] = 0;
        end
        repeat (3) tick();
        for (int i = 0; i < NI; i++) begin
            check_val($sformatf("i%0d_rst_seg", i), get_seg(i), 0);
            check_val($sformatf("i%0d_rst_flags", i), int'({neg_w[i], ovf_w[i], busy_w[i]}), 0);
            check_val($sformatf("i%0d_rst_op_idx", i), get_opi(i), 0);
        end
        rst = 1'b0;
        repeat (20) tick();

        run_calc(0, 0, '{7, 9, 0, 0, 0, 0, 0, 0}, 1'b0, 1'b1, 1'b0);
        check_val("plan_16_seg", int'(seg0), 14'h037D);
        run_calc(0, 1, '{3, 9, 0, 0, 0, 0, 0, 0}, 1'b0, 1'b0, 1'b0);
        check_val("plan_m06_seg", int'(seg0), 14'h1FFD);
        check_val("plan_m06_neg", int'(neg_w[0]), 1);
        run_calc(1, 0, '{15, 15, 15, 0, 0, 0, 0, 0}, 1'b0, 1'b0, 1'b0);
        check_val("plan_45_seg", int'(seg1), 14'h336D);
        run_calc(2, 0, '{9, 9, 0, 0, 0, 0, 0, 0}, 1'b0, 1'b0, 1'b0);
        check_val("plan_ovf_seg", int'(seg2), 7'h40);
        check_val("plan_ovf_flag", int'(ovf_w[2]), 1);

        for (int k = 0; k < 8; k++) ops[k] = int'($urandom_range(0, 255));
        run_calc(3, int'($urandom_range(0, 1)), ops, 1'b0, 1'b0, 1'b1);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NI; i++) begin
                for (int k = 0; k < 8; k++) ops[k] = int'($urandom_range(0, (1 << P_W[i]) - 1));
                run_calc(i, int'($urandom_range(0, 1)), ops, 1'(($urandom_range(0, 1))), 1'b0, 1'b0);
            end
        end

        // Reset during conversion on the widest instance, button held through reset.
        md[3] = 1'b0;
        for (int k = 0; k < P_N[3]-1; k++) press(3, int'($urandom_range(0, 255)));
        xv[3] = 8'd200;
        btn[3] = 1'b1;
        started = 0;
        for (int c = 0; c < 40 && started == 0; c++) begin
            tick();
            if (busy_w[3]) started = 1;
        end
        check_val("i3_conv_started", started, 1);
        repeat (2) tick();
        #2 rst = 1'b1;
        #1;
        check_val("rst_mid_busy", int'(busy_w[3]), 0);
        check_val("rst_mid_seg", get_seg(3), 0);
        check_val("rst_mid_op_idx", get_opi(3), 0);
        check_val("rst_mid_neg", int'(neg_w[3]), 0);
        repeat (5) tick();
        rst = 1'b0;
        repeat (30) tick();
        check_val("held_through_rst_op_idx", get_opi(3), 0);
        check_val("held_through_rst_busy", int'(busy_w[3]), 0);
        btn[3] = 1'b0;
        repeat (HOLD) tick();
        press(3, 5);
        check_val("after_rst_press_op_idx", get_opi(3), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
